// File: rtl/dsp_mac_scheduler.sv
// Sequencer for the shared DSP multiply-accumulate datapath: per sample tick, TAPS ops for ch0 then ch1,
// delayed result-store strobes, then one valid pulse. Optional macro SCHED_OVERRUN_COUNT_EN adds a dropped-tick counter.
module dsp_mac_scheduler #(
   parameter int TAPS        = 4,
   parameter int MAC_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick_in,
   input  logic                    clr_in,
   input  logic                    filter_en_in,
   output logic                    mac_en_out,
   output logic                    mac_start_out,
   output logic                    chan_out,
   output logic [$clog2(TAPS)-1:0] tap_out,
   output logic                    store_out,
   output logic                    store_chan_out,
   output logic                    valid_out,
   output logic                    bypass_out,
   output logic                    busy_out,
   output logic                    overrun_out
`ifdef SCHED_OVERRUN_COUNT_EN
   ,
   output logic [7:0]              overrun_count_out
`endif
);

   localparam int TAP_W = $clog2(TAPS);

   typedef enum logic [1:0] {S_IDLE, S_CH0, S_CH1, S_DRAIN} state_e;

   state_e                 state_q;
   logic                   mac_en_q, mac_start_q, chan_q;
   logic [TAP_W-1:0]       tap_q;
   logic                   valid_q, bypass_q, busy_q, overrun_q;
   logic [MAC_LATENCY-1:0] dl_v_q, dl_c_q;

   logic                   last_tap_d, store_in_d, store_chan_in_d, drain_done_d;
   logic [TAP_W-1:0]       tap_d;

   always_comb begin
      last_tap_d      = (tap_q == TAP_W'(TAPS - 1));
      tap_d           = tap_q + TAP_W'(1);
      store_in_d      = mac_en_q & last_tap_d;
      store_chan_in_d = store_in_d & chan_q;
      drain_done_d    = dl_v_q[MAC_LATENCY-1] & dl_c_q[MAC_LATENCY-1];
   end

   // The store delay line models the MAC pipeline; it is reset and flushed so an aborted run leaves no strobes.
   always_ff @(posedge clk) begin
      if (rst || clr_in) begin
         dl_v_q <= '0;
         dl_c_q <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage shift from its old value regardless of loop order.
         dl_v_q[0] <= store_in_d;
         dl_c_q[0] <= store_chan_in_d;
         for (int i = 1; i < MAC_LATENCY; i++) begin
            dl_v_q[i] <= dl_v_q[i-1];
            dl_c_q[i] <= dl_c_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mac_en_q    <= 1'b0;
         mac_start_q <= 1'b0;
         chan_q      <= 1'b0;
         tap_q       <= '0;
         valid_q     <= 1'b0;
         bypass_q    <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clr_in) begin
         state_q     <= S_IDLE;
         mac_en_q    <= 1'b0;
         mac_start_q <= 1'b0;
         chan_q      <= 1'b0;
         tap_q       <= '0;
         valid_q     <= 1'b0;
         bypass_q    <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         valid_q  <= 1'b0;
         bypass_q <= 1'b0;
         if (tick_in && busy_q) overrun_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (tick_in && filter_en_in) begin
                  state_q     <= S_CH0;
                  mac_en_q    <= 1'b1;
                  mac_start_q <= 1'b1;
                  chan_q      <= 1'b0;
                  tap_q       <= '0;
                  busy_q      <= 1'b1;
               end else if (tick_in) begin
                  valid_q  <= 1'b1;
                  bypass_q <= 1'b1;
               end
            end
            S_CH0: begin
               if (last_tap_d) begin
                  state_q     <= S_CH1;
                  chan_q      <= 1'b1;
                  tap_q       <= '0;
                  mac_start_q <= 1'b1;
               end else begin
                  tap_q       <= tap_d;
                  mac_start_q <= 1'b0;
               end
            end
            S_CH1: begin
               if (last_tap_d) begin
                  state_q     <= S_DRAIN;
                  mac_en_q    <= 1'b0;
                  mac_start_q <= 1'b0;
                  chan_q      <= 1'b0;
                  tap_q       <= '0;
               end else begin
                  tap_q       <= tap_d;
                  mac_start_q <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (drain_done_d) begin
                  state_q <= S_IDLE;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SCHED_OVERRUN_COUNT_EN
   logic [7:0] ovr_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr_in) begin
         ovr_cnt_q <= '0;
      end else if (tick_in && busy_q && (ovr_cnt_q != 8'hFF)) begin
         ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end
   end

   assign overrun_count_out = ovr_cnt_q;
`endif

   assign mac_en_out     = mac_en_q;
   assign mac_start_out  = mac_start_q;
   assign chan_out       = chan_q;
   assign tap_out        = tap_q;
   assign store_out      = dl_v_q[MAC_LATENCY-1];
   assign store_chan_out = dl_c_q[MAC_LATENCY-1];
   assign valid_out      = valid_q;
   assign bypass_out     = bypass_q;
   assign busy_out       = busy_q;
   assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_dsp_mac_scheduler.sv
// Self-checking bench for dsp_mac_scheduler: directed scenarios plus random traffic against a
// timeline model that derives every output from the cycle offset since the accepted tick.
module tb_dsp_mac_scheduler;

   localparam int TAPS    = 4;
   localparam int LAT     = 2;
   localparam int TW      = $clog2(TAPS);
   localparam int RUN_END = 2 * TAPS + LAT;   // last busy offset; valid follows one cycle later

   logic          clk = 1'b0;
   logic          rst, tick_in, clr_in, filter_en_in;
   logic          mac_en_out, mac_start_out, chan_out, store_out, store_chan_out;
   logic          valid_out, bypass_out, busy_out, overrun_out;
   logic [TW-1:0] tap_out;
`ifdef SCHED_OVERRUN_COUNT_EN
   logic [7:0]    overrun_count_out;
`endif

   dsp_mac_scheduler #(.TAPS(TAPS), .MAC_LATENCY(LAT)) dut (
      .clk            (clk),
      .rst            (rst),
      .tick_in        (tick_in),
      .clr_in         (clr_in),
      .filter_en_in   (filter_en_in),
      .mac_en_out     (mac_en_out),
      .mac_start_out  (mac_start_out),
      .chan_out       (chan_out),
      .tap_out        (tap_out),
      .store_out      (store_out),
      .store_chan_out (store_chan_out),
      .valid_out      (valid_out),
      .bypass_out     (bypass_out),
      .busy_out       (busy_out),
      .overrun_out    (overrun_out)
`ifdef SCHED_OVERRUN_COUNT_EN
      ,
      .overrun_count_out (overrun_count_out)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n      = 0;        // index of the cycle currently presented to the DUT
   bit m_run  = 1'b0;     // a filter run has been accepted
   int m_start = -1000;   // cycle in which that run's tick was accepted
   int m_byp_at = -1;     // cycle in which a bypass valid is due
   bit m_ovr  = 1'b0;
   int m_cnt  = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
      end
   endtask

   task automatic compare_all();
      int  k;
      bit  act, e_mac, e_start, e_store, e_schan, e_valid, e_byp, e_busy;
      int  e_chan, e_tap;
      k       = n - m_start;
      act     = m_run && (k >= 1) && (k <= RUN_END + 1);
      e_mac   = act && (k <= 2 * TAPS);
      e_chan  = e_mac ? (k - 1) / TAPS : 0;
      e_tap   = e_mac ? (k - 1) % TAPS : 0;
      e_start = e_mac && (e_tap == 0);
      e_store = act && ((k == TAPS + LAT) || (k == 2 * TAPS + LAT));
      e_schan = act && (k == 2 * TAPS + LAT);
      e_byp   = (m_byp_at == n);
      e_valid = (act && (k == RUN_END + 1)) || e_byp;
      e_busy  = act && (k <= RUN_END);
      check("mac_en",     {7'd0, mac_en_out},     {7'd0, e_mac});
      check("mac_start",  {7'd0, mac_start_out},  {7'd0, e_start});
      check("chan",       {7'd0, chan_out},       8'(e_chan));
      check("tap",        8'(tap_out),            8'(e_tap));
      check("store",      {7'd0, store_out},      {7'd0, e_store});
      check("store_chan", {7'd0, store_chan_out}, {7'd0, e_schan});
      check("valid",      {7'd0, valid_out},      {7'd0, e_valid});
      check("bypass",     {7'd0, bypass_out},     {7'd0, e_byp});
      check("busy",       {7'd0, busy_out},       {7'd0, e_busy});
      check("overrun",    {7'd0, overrun_out},    {7'd0, m_ovr});
`ifdef SCHED_OVERRUN_COUNT_EN
      check("overrun_count", overrun_count_out, 8'(m_cnt));
`endif
   endtask

   // Drive one cycle of inputs, advance the model across the clock edge, then compare everything.
   task automatic step(input logic t, input logic c, input logic f, input logic r);
      int k;
      bit busy_now;
      rst          = r;
      tick_in      = t;
      clr_in       = c;
      filter_en_in = f;
      k        = n - m_start;
      busy_now = m_run && (k >= 1) && (k <= RUN_END);
      if (r || c) begin
         m_run = 1'b0;
         m_ovr = 1'b0;
         m_cnt = 0;
      end else if (t) begin
         if (busy_now) begin
            m_ovr = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end else if (f) begin
            m_run   = 1'b1;
            m_start = n;
         end else begin
            m_byp_at = n + 1;
         end
      end
      @(posedge clk);
      #1;
      n++;
      compare_all();
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; tick_in = 1'b0; clr_in = 1'b0; filter_en_in = 1'b1;

      // Reset held two cycles with a tick pending: nothing may start.
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("reset_valid", {7'd0, valid_out}, 8'd0);
      idle(4);

      // Filter run: explicit landmarks for the default geometry, model covers every cycle.
      step(1'b1, 1'b0, 1'b1, 1'b0);                   // tick at T, now at T+1
      check("run_first_mac", {7'd0, mac_en_out}, 8'd1);
      idle(5);                                        // T+6
      check("run_store_ch0", {7'd0, store_out}, 8'd1);
      check("run_store_ch0_chan", {7'd0, store_chan_out}, 8'd0);
      idle(4);                                        // T+10
      check("run_store_ch1_chan", {7'd0, store_chan_out}, 8'd1);
      idle(1);                                        // T+11
      check("run_valid", {7'd0, valid_out}, 8'd1);
      check("run_valid_bypass", {7'd0, bypass_out}, 8'd0);
      idle(3);

      // Bypass: valid and bypass one cycle after the tick, no MAC activity.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("bypass_valid", {7'd0, valid_out & bypass_out}, 8'd1);
      idle(4);

      // Overrun: second tick four cycles into the run is dropped.
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(3);
      step(1'b1, 1'b0, 1'b1, 1'b0);                   // tick at T+4
      check("overrun_set", {7'd0, overrun_out}, 8'd1);
      idle(8);
      idle(300 % 1 + 2);

      // Abort mid-run, then clr together with tick.
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(5);
      step(1'b0, 1'b1, 1'b1, 1'b0);                   // clr at T+6
      check("abort_idle", {7'd0, busy_out}, 8'd0);
      idle(8);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_tick_nostart", {7'd0, mac_en_out | busy_out}, 8'd0);
      idle(2);

      // Back-to-back: tick in the valid cycle starts the next run without overrun.
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(10);                                       // now in T+11
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("b2b_mac", {7'd0, mac_en_out}, 8'd1);
      check("b2b_no_overrun", {7'd0, overrun_out}, 8'd0);
      idle(12);

      // Continuous ticks: far more than 255 drops, counter must saturate.
      for (int i = 0; i < 400; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SCHED_OVERRUN_COUNT_EN
      check("count_saturated", overrun_count_out, 8'd255);
`endif
      step(1'b0, 1'b1, 1'b1, 1'b0);

      // Random traffic including bypass, aborts and mid-run resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(3) == 0), ($urandom_range(31) == 0),
              ($urandom_range(3) != 0), ($urandom_range(199) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
